vec_run_ctrl: RTL and testbench

//  Parametrised run controller between board controls (start/pause/select) and the vector CPU core.

---
 rtl/vec_run_ctrl.sv | 143 ++++++++++++++
 tb/tb_vec_run_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vec_run_ctrl.sv
// Run controller for the vector core: latches a program slot, clears the core, gates execution,
// counts executed cycles and stops on halt or budget expiry. Optional macro: VEC_RUN_CTRL_STEP_EN.
module vec_run_ctrl #(
  parameter int unsigned NUM_PROGS  = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned CYC_W      = 32,
  parameter int unsigned MAX_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             step,
  input  logic [SEL_W-1:0] select,
  input  logic             halt,
  output logic [SEL_W-1:0] prog_sel,
  output logic             core_clear,
  output logic             run_en,
  output logic             busy,
  output logic             EndFlag,
  output logic             timeout,
  output logic             sel_err,
  output logic [CYC_W-1:0] cycle_count
);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StPaused, StDone} state_e;

  // Count value during the last cycle allowed by the budget.
  localparam logic [CYC_W-1:0] LP_BUDGET_LAST = CYC_W'(MAX_CYCLES - 1);

  state_e           r_state, w_state_d;
  logic             r_start_q;
  logic [SEL_W-1:0] r_prog_sel, w_prog_sel_d;
  logic [CYC_W-1:0] r_cycle_count, w_cycle_count_d;
  logic             r_timeout, w_timeout_d;
  logic             r_sel_err, w_sel_err_d;
  logic             w_start_edge;
  logic             w_sel_ok;
  logic             w_step_fire;
  logic             w_exec;
  logic             w_budget_hit;

`ifdef VEC_RUN_CTRL_STEP_EN
  logic r_step_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_step_q <= 1'b0;
    else        r_step_q <= step;
  end

  assign w_step_fire = (r_state == StPaused) && step && !r_step_q;
`else
  logic w_unused_step;

  assign w_unused_step = step;
  assign w_step_fire   = 1'b0;
`endif

  assign w_start_edge = start && !r_start_q;
  assign w_sel_ok     = 32'(select) < NUM_PROGS;
  assign w_exec       = (r_state == StRun) || w_step_fire;
  assign w_budget_hit = (MAX_CYCLES != 0) && (r_cycle_count == LP_BUDGET_LAST);

  always_comb begin
    w_state_d       = r_state;
    w_prog_sel_d    = r_prog_sel;
    w_cycle_count_d = r_cycle_count;
    w_timeout_d     = r_timeout;
    w_sel_err_d     = 1'b0;

    if (w_exec && (r_cycle_count != '1)) w_cycle_count_d = r_cycle_count + 1'b1;

    case (r_state)
      StIdle, StDone: begin
        if (w_start_edge) begin
          if (w_sel_ok) begin
            w_state_d    = StLoad;
            w_prog_sel_d = select;
          end else begin
            w_sel_err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        w_cycle_count_d = '0;
        w_timeout_d     = 1'b0;
        w_state_d       = pause ? StPaused : StRun;
      end
      StRun: begin
        // Halt outranks the budget, which outranks pause.
        if (halt) begin
          w_state_d   = StDone;
          w_timeout_d = 1'b0;
        end else if (w_budget_hit) begin
          w_state_d   = StDone;
          w_timeout_d = 1'b1;
        end else if (pause) begin
          w_state_d = StPaused;
        end
      end
      StPaused: begin
        if (w_step_fire && halt) begin
          w_state_d   = StDone;
          w_timeout_d = 1'b0;
        end else if (w_step_fire && w_budget_hit) begin
          w_state_d   = StDone;
          w_timeout_d = 1'b1;
        end else if (!pause) begin
          w_state_d = StRun;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= StIdle;
      r_start_q     <= 1'b0;
      r_prog_sel    <= '0;
      r_cycle_count <= '0;
      r_timeout     <= 1'b0;
      r_sel_err     <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_start_q     <= start;
      r_prog_sel    <= w_prog_sel_d;
      r_cycle_count <= w_cycle_count_d;
      r_timeout     <= w_timeout_d;
      r_sel_err     <= w_sel_err_d;
    end
  end

  assign prog_sel    = r_prog_sel;
  assign core_clear  = (r_state == StLoad);
  assign run_en      = w_exec;
  assign busy        = (r_state == StLoad) || (r_state == StRun) || (r_state == StPaused);
  assign EndFlag     = (r_state == StDone);
  assign timeout     = r_timeout;
  assign sel_err     = r_sel_err;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_vec_run_ctrl.sv
// Directed bench for vec_run_ctrl: unbounded instance (a_*) and a 3-slot, 8-cycle budget one (b_*).
module tb_vec_run_ctrl;

`ifdef VEC_RUN_CTRL_STEP_EN
  localparam int STEPS = 3;
`else
  localparam int STEPS = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       a_start, a_pause, a_step, a_halt;
  logic [1:0] a_sel, a_prog_sel;
  logic       a_core_clear, a_run_en, a_busy, a_end, a_timeout, a_sel_err;
  logic [31:0] a_cnt;

  logic       b_start, b_pause, b_step, b_halt;
  logic [1:0] b_sel, b_prog_sel;
  logic       b_core_clear, b_run_en, b_busy, b_end, b_timeout, b_sel_err;
  logic [7:0] b_cnt;

  int n_vec = 0;
  int n_err = 0;

  vec_run_ctrl #(.NUM_PROGS(4), .SEL_W(2), .CYC_W(32), .MAX_CYCLES(0)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .pause(a_pause), .step(a_step),
    .select(a_sel), .halt(a_halt), .prog_sel(a_prog_sel), .core_clear(a_core_clear),
    .run_en(a_run_en), .busy(a_busy), .EndFlag(a_end), .timeout(a_timeout),
    .sel_err(a_sel_err), .cycle_count(a_cnt)
  );

  vec_run_ctrl #(.NUM_PROGS(3), .SEL_W(2), .CYC_W(8), .MAX_CYCLES(8)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .pause(b_pause), .step(b_step),
    .select(b_sel), .halt(b_halt), .prog_sel(b_prog_sel), .core_clear(b_core_clear),
    .run_en(b_run_en), .busy(b_busy), .EndFlag(b_end), .timeout(b_timeout),
    .sel_err(b_sel_err), .cycle_count(b_cnt)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    {a_start, a_pause, a_step, a_halt, a_sel} = '0;
    {b_start, b_pause, b_step, b_halt, b_sel} = '0;
    cyc(5);
    chk("rst_busy", a_busy, 0);
    chk("rst_run_en", a_run_en, 0);
    chk("rst_clear", a_core_clear, 0);
    chk("rst_end", a_end, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_psel", a_prog_sel, 0);
    chk("rst_selerr", b_sel_err, 0);
    reset = 1'b1;
    cyc(1);

    // Load slot 2, run 10 cycles, halt on the 11th.
    a_sel = 2; a_start = 1;
    cyc(1);
    chk("load_clear", a_core_clear, 1);
    chk("load_psel", a_prog_sel, 2);
    chk("load_busy", a_busy, 1);
    chk("load_run_en", a_run_en, 0);
    a_start = 0;
    cyc(1);
    chk("run_en", a_run_en, 1);
    chk("run_clear", a_core_clear, 0);
    chk("run_cnt0", a_cnt, 0);
    cyc(10);
    chk("pre_halt_cnt", a_cnt, 10);
    a_halt = 1;
    cyc(1);
    a_halt = 0;
    chk("halt_cnt", a_cnt, 11);
    chk("halt_end", a_end, 1);
    chk("halt_tmo", a_timeout, 0);
    chk("halt_run_en", a_run_en, 0);
    chk("halt_busy", a_busy, 0);
    cyc(3);
    chk("done_hold_cnt", a_cnt, 11);

    // Restart from DONE with start held high: one run only.
    a_sel = 1; a_start = 1;
    cyc(1);
    chk("rs_psel", a_prog_sel, 1);
    chk("rs_clear", a_core_clear, 1);
    cyc(1);
    chk("rs_cnt0", a_cnt, 0);
    cyc(3);
    a_halt = 1;
    cyc(1);
    a_halt = 0;
    chk("rs_end", a_end, 1);
    chk("rs_cnt", a_cnt, 4);
    for (int i = 0; i < 45; i++) begin
      cyc(1);
      chk("hold_busy", a_busy, 0);
    end
    chk("hold_cnt", a_cnt, 4);
    chk("hold_end", a_end, 1);
    a_start = 0;
    cyc(1);

    // Pause after 5 run cycles; the cycle pause is first seen still executes.
    a_sel = 3; a_start = 1;
    cyc(1);
    a_start = 0;
    cyc(1);
    chk("p_cnt0", a_cnt, 0);
    cyc(5);
    chk("p_cnt5", a_cnt, 5);
    chk("p_run_en_hi", a_run_en, 1);
    a_pause = 1;
    cyc(1);
    chk("p_cnt6", a_cnt, 6);
    chk("p_run_en_lo", a_run_en, 0);
    chk("p_busy", a_busy, 1);
    a_sel = 0; a_start = 1;
    cyc(1);
    a_start = 0;
    cyc(17);
    chk("p_frozen", a_cnt, 6);
    chk("p_psel", a_prog_sel, 3);
    chk("p_run_en", a_run_en, 0);
    chk("p_no_selerr", a_sel_err, 0);

    for (int i = 0; i < 3; i++) begin
      a_step = 1;
      #1;
      chk("st_en", a_run_en, (STEPS != 0) ? 1 : 0);
      cyc(1);
      a_step = 0;
      #1;
      chk("st_en_lo", a_run_en, 0);
      cyc(1);
    end
    chk("st_cnt", a_cnt, 6 + STEPS);
    chk("st_busy", a_busy, 1);

    a_pause = 0;
    cyc(1);
    chk("res_run_en", a_run_en, 1);
    chk("res_cnt", a_cnt, 6 + STEPS);
    cyc(1);
    chk("res_cnt1", a_cnt, 7 + STEPS);
    a_halt = 1; a_pause = 1;
    cyc(1);
    a_halt = 0; a_pause = 0;
    chk("hp_end", a_end, 1);
    chk("hp_busy", a_busy, 0);
    chk("hp_cnt", a_cnt, 8 + STEPS);

    // Invalid select in IDLE.
    b_sel = 3; b_start = 1;
    cyc(1);
    chk("b_selerr", b_sel_err, 1);
    chk("b_idle_busy", b_busy, 0);
    chk("b_idle_psel", b_prog_sel, 0);
    cyc(1);
    chk("b_selerr_pulse", b_sel_err, 0);
    b_start = 0;
    cyc(1);

    // Budget expiry at cycle_count == 8.
    b_sel = 1; b_start = 1;
    cyc(1);
    chk("b_load", b_core_clear, 1);
    b_start = 0;
    cyc(1);
    chk("b_cnt0", b_cnt, 0);
    cyc(7);
    chk("b_cnt7", b_cnt, 7);
    chk("b_run_en7", b_run_en, 1);
    chk("b_end7", b_end, 0);
    cyc(1);
    chk("b_tmo_cnt", b_cnt, 8);
    chk("b_tmo", b_timeout, 1);
    chk("b_tmo_end", b_end, 1);
    chk("b_tmo_run_en", b_run_en, 0);

    b_sel = 3; b_start = 1;
    cyc(1);
    chk("b_done_selerr", b_sel_err, 1);
    chk("b_done_end", b_end, 1);
    chk("b_done_psel", b_prog_sel, 1);
    b_start = 0;
    cyc(1);

    // Halt on the budget's last cycle wins: timeout stays 0.
    b_sel = 2; b_start = 1;
    cyc(1);
    b_start = 0;
    cyc(1);
    chk("b_tmo_clr", b_timeout, 0);
    chk("b_psel2", b_prog_sel, 2);
    cyc(7);
    b_halt = 1;
    cyc(1);
    b_halt = 0;
    chk("b_ht_tmo", b_timeout, 0);
    chk("b_ht_end", b_end, 1);
    chk("b_ht_cnt", b_cnt, 8);

    // Reset mid-run clears outputs without waiting for a clock.
    a_sel = 2; a_start = 1;
    cyc(1);
    a_start = 0;
    cyc(4);
    chk("mr_run_en_hi", a_run_en, 1);
    reset = 0;
    #1;
    chk("mr_run_en", a_run_en, 0);
    chk("mr_busy", a_busy, 0);
    chk("mr_cnt", a_cnt, 0);
    chk("mr_psel", a_prog_sel, 0);
    chk("mr_end", b_end, 0);
    cyc(2);
    reset = 1;
    cyc(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
